drv_port_fifo: RTL and testbench

//   Per-device transmit FIFO feeding one port of the bus generator/arbiter (bs_gnrtr_n_rbtr).
//   A device-side producer writes packets; the bus side sees a show-ahead head word (D_pop) and
//   a pending flag (pndng), and removes words with pop.
//   One instance per driver; the top level instantiates drvrs copies and concatenates

---
 rtl/drv_port_fifo.sv | 91 +++++++++
 tb/tb_drv_port_fifo.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/drv_port_fifo.sv
// Per-device transmit FIFO for one bus port: show-ahead head word,
// pending/full flags and saturating overflow/underflow event counters.
module drv_port_fifo #(
    parameter int pckg_sz = 16,
    parameter int depth   = 8,
    parameter int cnt_w   = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [pckg_sz-1:0]       wr_data,
    output logic                     full,
    input  logic                     pop,
    output logic [pckg_sz-1:0]       D_pop,
    output logic                     pndng,
    output logic [$clog2(depth):0]   count,
    output logic [cnt_w-1:0]         ovf_cnt,
    output logic [cnt_w-1:0]         udf_cnt
);

    localparam int AW = $clog2(depth);
    localparam int CW = AW + 1;

    logic [pckg_sz-1:0] mem_q [depth];
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [cnt_w-1:0]   ovf_q, ovf_d;
    logic [cnt_w-1:0]   udf_q, udf_d;

    logic empty_w, full_w;
    logic pop_eff, wr_acc;

    // Flags decode from the registered count only, never from pointers.
    assign empty_w = (cnt_q == '0);
    assign full_w  = (cnt_q == CW'(depth));

    assign pop_eff = pop & ~empty_w;
    assign wr_acc  = wr_en & (~full_w | pop_eff);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q + CW'(wr_acc) - CW'(pop_eff);
        ovf_d    = ovf_q;
        udf_d    = udf_q;
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_eff) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (wr_en && !wr_acc && (ovf_q != '1)) begin
            ovf_d = ovf_q + cnt_w'(1);
        end
        if (pop && empty_w && (udf_q != '1)) begin
            udf_d = udf_q + cnt_w'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= '0;
            udf_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    // Storage is intentionally left uncleared by reset.
    always_ff @(posedge clk) begin
        if (!reset && wr_acc) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign pndng   = ~empty_w;
    assign full    = full_w;
    assign count   = cnt_q;
    assign D_pop   = empty_w ? '0 : mem_q[rd_ptr_q];
    assign ovf_cnt = ovf_q;
    assign udf_cnt = udf_q;

endmodule

// File: tb/tb_drv_port_fifo.sv
// Self-checking bench for drv_port_fifo: directed scenarios plus random
// traffic against a queue-based reference model.
module tb_drv_port_fifo;

    localparam int PW = 16;
    localparam int DEPTH = 8;
    localparam int CNTW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          wr_en;
    logic [PW-1:0] wr_data;
    logic          full;
    logic          pop;
    logic [PW-1:0] D_pop;
    logic          pndng;
    logic [3:0]    count;
    logic [CNTW-1:0] ovf_cnt;
    logic [CNTW-1:0] udf_cnt;

    int checks = 0;
    int errors = 0;

    logic [PW-1:0] mq [$];
    int m_ovf = 0;
    int m_udf = 0;

    drv_port_fifo #(.pckg_sz(PW), .depth(DEPTH), .cnt_w(CNTW)) dut (
        .clk(clk),
        .reset(reset),
        .wr_en(wr_en),
        .wr_data(wr_data),
        .full(full),
        .pop(pop),
        .D_pop(D_pop),
        .pndng(pndng),
        .count(count),
        .ovf_cnt(ovf_cnt),
        .udf_cnt(udf_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [PW-1:0] head;
        head = (mq.size() != 0) ? mq[0] : '0;
        check({tag, "_count"}, 32'(count), 32'(mq.size()));
        check({tag, "_pndng"}, 32'(pndng), 32'(mq.size() != 0));
        check({tag, "_full"},  32'(full),  32'(mq.size() == DEPTH));
        check({tag, "_head"},  32'(D_pop), 32'(head));
        check({tag, "_ovf"},   32'(ovf_cnt), 32'(m_ovf));
        check({tag, "_udf"},   32'(udf_cnt), 32'(m_udf));
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        wr_en = $urandom_range(0, 1);
        pop = $urandom_range(0, 1);
        wr_data = 16'(
            $urandom());
        @(posedge clk);
        mq.delete();
        m_ovf = 0;
        m_udf = 0;
        #1;
        reset = 1'b0;
        check_all("rst");
    endtask

    task automatic step(input bit w, input logic [PW-1:0] d, input bit p,
                        input string tag);
        bit pe, acc;
        @(negedge clk);
        reset = 1'b0;
        wr_en = w;
        wr_data = d;
        pop = p;
        @(posedge clk);
        pe  = p && (mq.size() > 0);
        acc = w && ((mq.size() < DEPTH) || pe);
        if (p && mq.size() == 0 && m_udf < 255) m_udf++;
        if (w && !acc && m_ovf < 255) m_ovf++;
        if (pe) void'(mq.pop_front());
        if (acc) mq.push_back(d);
        #1;
        check_all(tag);
    endtask

    initial begin
        reset = 1'b1;
        wr_en = 1'b0;
        pop = 1'b0;
        wr_data = '0;
        repeat (2) @(posedge clk);
        do_reset();

        step(1, 16'hA001, 0, "t1w");
        step(1, 16'hA002, 0, "t1w");
        step(1, 16'hA003, 0, "t1w");
        check("t1_cnt3", 32'(count), 32'd3);
        check("t1_head", 32'(D_pop), 32'hA001);
        step(0, 16'h0, 1, "t1p");
        check("t1_head2", 32'(D_pop), 32'hA002);
        step(0, 16'h0, 1, "t1p");
        check("t1_head3", 32'(D_pop), 32'hA003);
        step(0, 16'h0, 1, "t1p");
        check("t1_empty", 32'(pndng), 32'd0);
        check("t1_zero", 32'(D_pop), 32'd0);

        do_reset();
        for (int i = 0; i < DEPTH; i++) step(1, 16'(16'hF0 + i), 0, "t2f");
        check("t2_full", 32'(full), 32'd1);
        step(1, 16'h1111, 0, "t2o");
        step(1, 16'h2222, 0, "t2o");
        check("t2_ovf", 32'(ovf_cnt), 32'd2);
        check("t2_cnt", 32'(count), 32'd8);
        check("t2_head", 32'(D_pop), 32'hF0);

        step(1, 16'hBEEF, 1, "t3");
        check("t3_cnt", 32'(count), 32'd8);
        check("t3_full", 32'(full), 32'd1);
        for (int i = 0; i < 7; i++) step(0, 16'h0, 1, "t3p");
        check("t3_beef", 32'(D_pop), 32'hBEEF);

        for (int i = 0; i < 300; i++) step(1, 16'(i), 0, "sat");
        check("sat_ovf", 32'(ovf_cnt), 32'd255);

        do_reset();
        for (int i = 0; i < 3; i++) step(0, 16'h0, 1, "t4u");
        check("t4_udf", 32'(udf_cnt), 32'd3);
        step(1, 16'h4444, 1, "t4wp");
        check("t4_cnt", 32'(count), 32'd1);
        check("t4_udf4", 32'(udf_cnt), 32'd4);
        check("t4_head", 32'(D_pop), 32'h4444);
        step(0, 16'h0, 1, "t4d");

        for (int i = 0; i < 20; i++) begin
            step(1, 16'(16'h5000 + i), 0, "t5w");
            check("t5_order", 32'(D_pop), 32'(16'h5000 + i));
            step(0, 16'h0, 1, "t5p");
        end

        for (int i = 0; i < 5; i++) step(1, 16'(16'h6000 + i), 0, "t6w");
        check("t6_cnt5", 32'(count), 32'd5);
        do_reset();
        check("t6_pndng", 32'(pndng), 32'd0);
        check("t6_dpop", 32'(D_pop), 32'd0);
        step(1, 16'h1234, 0, "t6n");
        check("t6_new", 32'(D_pop), 32'h1234);

        for (int i = 0; i < 400; i++) begin
            step(bit'($urandom_range(0, 1)), 16'($urandom()),
                 bit'($urandom_range(0, 2) == 0), "rnd");
        end
        for (int i = 0; i < 400; i++) begin
            step(bit'($urandom_range(0, 2) == 0), 16'($urandom()),
                 bit'($urandom_range(0, 1)), "rnd2");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
